// File: rtl/comparator_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : comparator_serial_nbit
// Description : Multi-cycle MSB-first magnitude comparator, CHUNK bits/cycle,
//               with signed (offset-binary) mode and optional early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial_nbit #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 2,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int               c_NUM_SLICES = WIDTH / CHUNK;
    localparam int               c_IDX_W      = (c_NUM_SLICES > 1) ? $clog2(c_NUM_SLICES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_SLICES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [WIDTH-1:0] c_MSB        = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("comparator_serial_nbit: illegal WIDTH/CHUNK combination");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_dec;
    logic               r_dec_lt;
    logic               r_eq;
    logic               r_lt;
    logic               r_gt;

    logic [CHUNK-1:0]   w_sa;
    logic [CHUNK-1:0]   w_sb;
    logic               w_diff;
    logic               w_slice_lt;
    logic               w_last;
    logic               w_fin;
    logic               w_fin_eq;
    logic               w_fin_lt;
    logic               w_fin_gt;

    // Slice compare and the result that would be registered on entry to DONE
    always_comb begin
        w_sa       = r_a[r_idx*CHUNK +: CHUNK];
        w_sb       = r_b[r_idx*CHUNK +: CHUNK];
        w_diff     = (w_sa != w_sb);
        w_slice_lt = (w_sa < w_sb);
        w_last     = (r_idx == '0);
        w_fin      = w_last || (EARLY_EXIT && w_diff);
        w_fin_eq   = 1'b0;
        w_fin_lt   = 1'b0;
        w_fin_gt   = 1'b0;
        if (r_dec) begin
            w_fin_lt = r_dec_lt;
            w_fin_gt = ~r_dec_lt;
        end else if (w_diff) begin
            w_fin_lt = w_slice_lt;
            w_fin_gt = ~w_slice_lt;
        end else begin
            w_fin_eq = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_S_IDLE;
        unique case (r_state)
            c_S_IDLE: w_state_nxt = start ? c_S_RUN : c_S_IDLE;
            c_S_RUN:  w_state_nxt = w_fin ? c_S_DONE : c_S_RUN;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Signed operands are stored offset-binary so the slice compare stays unsigned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_dec    <= 1'b0;
            r_dec_lt <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
        end else begin
            unique case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_a      <= a ^ (signed_mode ? c_MSB : '0);
                        r_b      <= b ^ (signed_mode ? c_MSB : '0);
                        r_idx    <= c_LAST_IDX;
                        r_dec    <= 1'b0;
                        r_dec_lt <= 1'b0;
                    end
                end
                c_S_RUN: begin
                    if (w_diff && !r_dec) begin
                        r_dec    <= 1'b1;
                        r_dec_lt <= w_slice_lt;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx - c_IDX_ONE;
                    end
                    if (w_fin) begin
                        r_eq <= w_fin_eq;
                        r_lt <= w_fin_lt;
                        r_gt <= w_fin_gt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != c_S_IDLE);
    assign done = (r_state == c_S_DONE);
    assign eq   = r_eq;
    assign lt   = r_lt;
    assign gt   = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_comparator_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_serial_nbit
// Description : Scoreboard bench: directed vectors on 8/2 (both exit modes)
//               plus random sweeps over several WIDTH/CHUNK shapes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_serial_nbit;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    typedef struct {
        logic [2:0] f;
        int         cyc;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       md;
        logic [2:0] f;
        int         k;
    } vec_t;

    logic clk;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fin_cnt  = 0;

    // k = 1-based position (from MSB) of first differing 2-bit slice, after signed offset
    vec_t dir_vecs [11] = '{
        '{8'h5A, 8'h5A, 1'b0, F_EQ, 4},
        '{8'h80, 8'h7F, 1'b0, F_GT, 1},
        '{8'h80, 8'h7F, 1'b1, F_LT, 1},
        '{8'h00, 8'hFF, 1'b1, F_GT, 1},
        '{8'h00, 8'hFF, 1'b0, F_LT, 1},
        '{8'hC0, 8'h00, 1'b0, F_GT, 1},
        '{8'h03, 8'h02, 1'b0, F_GT, 4},
        '{8'h01, 8'h01, 1'b1, F_EQ, 4},
        '{8'h7F, 8'h7E, 1'b1, F_GT, 4},
        '{8'h80, 8'h81, 1'b1, F_LT, 4},
        '{8'h24, 8'h28, 1'b0, F_LT, 3}
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar e = 0; e < 2; e++) begin : g_dir
        localparam bit EE = (e == 1);
        logic       rst_l, start, mode, busy, done, eq, lt, gt;
        logic [7:0] a, b;
        exp_t       q [$];
        int         brun = 0;

        comparator_serial_nbit #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(EE)) u_dut (
            .clk(clk), .rst_n(rst_l), .start(start), .signed_mode(mode),
            .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
        );

        always @(negedge clk) begin
            brun <= busy ? brun + 1 : 0;
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL dir%0d spurious_done: got done=1 expected no done", e);
                end else begin
                    check($sformatf("dir%0d flags", e), {eq, lt, gt}, q[0].f);
                    check($sformatf("dir%0d done_cycle", e), cyc, q[0].cyc);
                    check($sformatf("dir%0d busy_cycles", e), brun + 1, q[0].lat + 1);
                    void'(q.pop_front());
                end
            end
        end

        task automatic wait_idle();
            for (int t = 0; t < 64 && busy; t++) @(negedge clk);
            check($sformatf("dir%0d idle_timeout", e), busy, 1'b0);
        endtask

        task automatic run_vec(input logic [7:0] av, input logic [7:0] bv, input logic md,
                               input logic [2:0] f, input int k);
            int lat;
            lat = EE ? k : 4;
            @(negedge clk);
            a = av; b = bv; mode = md; start = 1'b1;
            q.push_back('{f, cyc + 1 + lat, lat});
            @(negedge clk);
            start = 1'b0;
            wait_idle();
            @(negedge clk);
            check($sformatf("dir%0d hold_%02h_%02h", e, av, bv), {eq, lt, gt}, f);
        endtask

        initial begin : drv
            int lat;
            rst_l = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
            repeat (2) @(negedge clk);
            rst_l = 1'b1;
            check($sformatf("dir%0d reset_state", e), {busy, done, eq, lt, gt}, 5'b0);

            foreach (dir_vecs[i])
                run_vec(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].md, dir_vecs[i].f, dir_vecs[i].k);

            // start held high: back-to-back compares every N+2 cycles
            @(negedge clk);
            a = 8'h5A; b = 8'h5A; mode = 1'b0; start = 1'b1;
            q.push_back('{F_EQ, cyc + 1 + 4, 4});
            q.push_back('{F_EQ, cyc + 1 + 10, 4});
            repeat (7) @(negedge clk);
            start = 1'b0;
            wait_idle();

            // start re-pulsed while busy and operands toggled mid-run
            @(negedge clk);
            a = 8'h10; b = 8'h20; mode = 1'b0; start = 1'b1;
            lat = EE ? 2 : 4;
            q.push_back('{F_LT, cyc + 1 + lat, lat});
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk);
                if (i == 1) check($sformatf("dir%0d hold_in_run", e), {eq, lt, gt}, F_EQ);
                if (i == 2) begin
                    start = 1'b1; a = 8'hFF; b = 8'h00;
                end else begin
                    start = 1'b0; a = ~a; b = ~b;
                end
            end
            wait_idle();
            repeat (3) @(negedge clk);

            // reset during RUN aborts without a done pulse
            @(negedge clk);
            a = 8'h01; b = 8'h02; mode = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            rst_l = 1'b0;
            @(negedge clk);
            rst_l = 1'b1;
            check($sformatf("dir%0d after_reset", e), {busy, done, eq, lt, gt}, 5'b0);
            repeat (6) @(negedge clk);
            run_vec(8'h01, 8'h01, 1'b0, F_EQ, 4);

            repeat (3) @(negedge clk);
            check($sformatf("dir%0d pending", e), q.size(), 0);
            fin_cnt++;
        end
    end

    for (genvar s = 0; s < 4; s++) begin : g_sweep
        localparam int W  = (s == 0) ? 1 : (s == 1) ? 8 : (s == 2) ? 16 : 12;
        localparam int C  = (s == 0) ? 1 : (s == 1) ? 8 : (s == 2) ? 4  : 3;
        localparam bit EE = (s == 1) || (s == 2);
        localparam int N  = W / C;
        logic         rst_l, start, mode, busy, done, eq, lt, gt;
        logic [W-1:0] a, b;
        exp_t         q [$];
        int           brun  = 0;
        int           ndone = 0;
        int           nacc  = 0;

        comparator_serial_nbit #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(EE)) u_dut (
            .clk(clk), .rst_n(rst_l), .start(start), .signed_mode(mode),
            .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
        );

        always @(negedge clk) begin
            brun <= busy ? brun + 1 : 0;
            if (done) begin
                ndone <= ndone + 1;
                check($sformatf("sw%0d onehot", s), $countones({eq, lt, gt}), 1);
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sw%0d spurious_done: got done=1 expected no done", s);
                end else begin
                    check($sformatf("sw%0d flags", s), {eq, lt, gt}, q[0].f);
                    check($sformatf("sw%0d done_cycle", s), cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end

        initial begin : drv
            logic [W-1:0] av, bv, x;
            logic         md;
            longint       sa, sb;
            int           h, k, lat;
            logic [2:0]   f;
            rst_l = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
            repeat (2) @(negedge clk);
            rst_l = 1'b1;
            for (int t = 0; t < 400; t++) begin
                av = W'($urandom);
                bv = W'($urandom);
                md = t[0];
                if (t < 2)       begin av = '0; bv = '1; end
                else if (t < 4)  begin av = '1; bv = '0; end
                else if (t % 16 == 0) bv = av;
                sa = longint'(av);
                sb = longint'(bv);
                if (md && av[W-1]) sa = sa - (longint'(1) << W);
                if (md && bv[W-1]) sb = sb - (longint'(1) << W);
                f = (sa == sb) ? F_EQ : (sa < sb) ? F_LT : F_GT;
                x = av ^ bv;
                h = 0;
                for (int j = 0; j < W; j++) if (x[j]) h = j;
                k = (x == '0) ? N : N - h / C;
                lat = EE ? k : N;
                @(negedge clk);
                a = av; b = bv; mode = md; start = 1'b1;
                q.push_back('{f, cyc + 1 + lat, lat});
                nacc++;
                @(negedge clk);
                start = 1'b0;
                for (int t2 = 0; t2 < 64 && busy; t2++) @(negedge clk);
                check($sformatf("sw%0d idle_timeout", s), busy, 1'b0);
            end
            repeat (3) @(negedge clk);
            check($sformatf("sw%0d done_count", s), ndone, nacc);
            check($sformatf("sw%0d pending", s), q.size(), 0);
            fin_cnt++;
        end
    end

    initial begin : main
        for (int t = 0; t < 40000 && fin_cnt < 6; t++) @(negedge clk);
        if (fin_cnt < 6) begin
            n_checks++;
            $display("FAIL timeout: got %0d drivers finished expected 6", fin_cnt);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparator_serial_nbit.md
Name: comparator_serial_nbit

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It extends the team's single-bit eq/lt/gt comparator to N-bit words, with a signed mode and an optional early-exit mode.
- Operands are captured on a start handshake and compared MSB-first, CHUNK bits per cycle. A one-cycle done pulse marks completion, and registered eq/lt/gt flags hold until the next completion.
- Used wherever a wide compare must be split across cycles to save area or meet timing.

Parameters:
- WIDTH, 8: operand width in bits; WIDTH >= 1.
- CHUNK, 2: bits compared per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (elaboration error otherwise).
- EARLY_EXIT, 0: 1 = finish on the first unequal slice; 0 = always process all slices (fixed latency).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a comparison; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare; captured with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse: result valid and newly updated.
- eq  output  1  A == B (registered).
- lt  output  1  A < B (registered).
- gt  output  1  A > B (registered).

Behaviour:
- Reset: one clock; rst_n is a synchronous, active-low reset. When rst_n = 0 at a rising edge:
  - state becomes IDLE.
  - busy, done, eq, lt and gt all become 0.
  - Internal operand and slice registers are cleared.
  - Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE. Let N = WIDTH/CHUNK.
- IDLE:
  - If start = 1 at an edge, capture a, b and signed_mode, set the slice index to N-1 and go to RUN.
  - In signed mode, invert the MSB of both captured operands (offset-binary), so the remaining logic is purely unsigned.
- RUN, each edge:
  - Compare slice [idx*CHUNK +: CHUNK] of the captured A against the same slice of captured B. Slices are taken MSB slice first.
  - Unequal slice, EARLY_EXIT = 1: latch gt/lt from that slice, eq = 0, go to DONE.
  - Unequal slice, EARLY_EXIT = 0: record the decision at the first unequal slice only. Later slices never override it.
  - After slice 0 with no decision recorded: go to DONE.
  - At the edge entering DONE, register {eq, lt, gt}. The result is exactly one-hot: eq = 1 if no slice differed, otherwise lt or gt per the first differing slice.
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally. start is not accepted in DONE.
- Latency: start accepted at edge E0.
  - EARLY_EXIT = 0: done is high in the cycle after edge E0+N.
  - EARLY_EXIT = 1: done is high in the cycle after edge E0+k, where k is the 1-based position of the first differing slice from the MSB (k = N if the operands are equal).
- Throughput: with start held high, one compare per N+2 cycles (EARLY_EXIT = 0).
- Operand and input stability:
  - a, b and signed_mode are ignored outside the accept edge; changing them mid-operation has no effect.
  - start is ignored while busy = 1; it is not queued.
- Result hold:
  - eq/lt/gt keep their last value through IDLE and through the next RUN until they are overwritten on entry to DONE.
  - Before the first completion after reset, all three are 0.
- Boundary cases:
  - WIDTH = CHUNK (N = 1): a single RUN cycle.
  - signed_mode with WIDTH = 1: the values are 0 and -1, so a = 1 gives lt against b = 0.
  - All-zeros vs all-ones: unsigned gives lt. Signed 0 vs -1 gives gt.

Test Plan:
- Equal operands, unsigned:
  - WIDTH = 8, CHUNK = 2, EARLY_EXIT = 0, a = 0x5A, b = 0x5A, start pulse.
  - Required: busy = 1 for 5 cycles; done in the cycle after edge E0+4; eq = 1, lt = 0, gt = 0; flags hold after done.
- Unsigned vs signed:
  - a = 0x80, b = 0x7F, signed_mode = 0 -> gt = 1.
  - Repeat with signed_mode = 1 -> lt = 1.
  - a = 0x00, b = 0xFF, signed -> gt = 1.
- Early exit:
  - EARLY_EXIT = 1, a = 0xC0, b = 0x00 -> done one edge after accept, gt = 1.
  - a = 0x03, b = 0x02 -> done after 4 RUN edges, gt = 1.
  - The same vectors with EARLY_EXIT = 0 take 4 RUN edges each.
- Start while busy and operand changes:
  - Start with a = 0x10, b = 0x20.
  - Pulse start again at RUN cycle 2 with a = 0xFF, b = 0x00, and toggle a/b every cycle.
  - Required: a single done; lt = 1 (first operands only).
- Reset mid-operation:
  - Drive rst_n = 0 for one edge during RUN -> next cycle busy = done = eq = lt = gt = 0, no done pulse.
  - A new start (a = 0x01, b = 0x01) then completes normally with eq = 1.
- Parameter sweep:
  - (WIDTH, CHUNK) = (1,1), (8,8), (16,4), (12,3), each with 200 random operand pairs in both modes.
  - Flags must match a reference signed/unsigned compare.
  - done count must equal accepted starts, and {eq, lt, gt} must be one-hot at every done.
